isram_ctrl: RTL and testbench

Sequencing controller for the 4-way I-cache status array (`isram`, 2-bit {dirty, valid} per way per set). It arbitrates between flush, fill and lookup requests and drives the array's single port. It returns per-set valid/dirty masks for lookups and selects a victim way for fills. It also sweeps the array to all-invalid after reset and on demand. It sits between the I-cache miss/refill logic and the `isram` instance.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/isram_victim_sel.sv | 23 ++
 rtl/isram_ctrl.sv | 178 +++++++++++++++++
 tb/tb_isram_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared I-cache definitions: status-array FSM encoding, way count and status bit layout.
package icache_pkg;

    localparam int I_INDEX_WIDTH = 6;
    localparam int ICACHE_WAYS   = 4;

    localparam int ST_VALID = 0;
    localparam int ST_DIRTY = 1;

    // Status written by a refill: valid, clean.
    localparam logic [1:0] ST_FILL = 2'b01;

    typedef enum logic [1:0] {
        S_FLUSH,
        S_IDLE,
        S_FILL_RD,
        S_FILL_WR
    } isram_state_e;

endpackage

// File: rtl/isram_victim_sel.sv
// Victim selection: lowest-numbered invalid way, or the round-robin pointer when the set is full.
module isram_victim_sel
    import icache_pkg::*;
(
    input  logic [ICACHE_WAYS-1:0] vmask,
    input  logic [1:0]             rr_ptr,
    output logic [1:0]             victim,
    output logic                   use_rr
);

    always_comb begin
        victim = rr_ptr;
        use_rr = 1'b1;
        // Descending scan so the lowest invalid way is the last one assigned.
        for (int i = ICACHE_WAYS - 1; i >= 0; i--) begin
            if (!vmask[i]) begin
                victim = 2'(i);
                use_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/isram_ctrl.sv
// Status-array sequencer for the 4-way I-cache: flush sweep, fill with victim selection, lookups.
// Define ISRAM_RESET_FLUSH_EN to sweep the array invalid coming out of reset.
module isram_ctrl
    import icache_pkg::*;
#(
    parameter int aw = I_INDEX_WIDTH,
    parameter int dw = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lookup_valid,
    output logic          lookup_ready,
    input  logic [aw-1:0] lookup_index,
    output logic          resp_valid,
    output logic [3:0]    resp_vmask,
    output logic [3:0]    resp_dmask,
    input  logic          fill_valid,
    output logic          fill_ready,
    input  logic [aw-1:0] fill_index,
    output logic          fill_done,
    output logic [1:0]    fill_way,
    input  logic          flush_req,
    output logic          flush_busy,
    output logic          sram_en,
    output logic          sram_we,
    output logic [aw-1:0] sram_index,
    output logic [1:0]    sram_way,
    output logic [dw-1:0] sram_din,
    input  logic [dw-1:0] sram_dout0,
    input  logic [dw-1:0] sram_dout1,
    input  logic [dw-1:0] sram_dout2,
    input  logic [dw-1:0] sram_dout3
);

    localparam int FW = aw + 2;

`ifdef ISRAM_RESET_FLUSH_EN
    localparam isram_state_e RESET_STATE = S_FLUSH;
`else
    localparam isram_state_e RESET_STATE = S_IDLE;
`endif

    isram_state_e  state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]    victim_q, victim_d;
    logic          use_rr_q, use_rr_d;
    logic [aw-1:0] index_q, index_d;
    logic          resp_valid_q, resp_valid_d;
    logic [3:0]    vmask_q, vmask_d;
    logic [3:0]    dmask_q, dmask_d;

    logic          en_c, we_c;
    logic [aw-1:0] idx_c;
    logic [1:0]    way_c;
    logic [dw-1:0] din_c;
    logic [3:0]    rd_vmask, rd_dmask;
    logic [1:0]    sel_victim;
    logic          sel_use_rr;

    assign rd_vmask = {sram_dout3[ST_VALID], sram_dout2[ST_VALID],
                       sram_dout1[ST_VALID], sram_dout0[ST_VALID]};
    assign rd_dmask = {sram_dout3[ST_DIRTY], sram_dout2[ST_DIRTY],
                       sram_dout1[ST_DIRTY], sram_dout0[ST_DIRTY]};

    isram_victim_sel u_victim_sel (
        .vmask  (rd_vmask),
        .rr_ptr (rr_ptr_q),
        .victim (sel_victim),
        .use_rr (sel_use_rr)
    );

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        rr_ptr_d     = rr_ptr_q;
        victim_d     = victim_q;
        use_rr_d     = use_rr_q;
        index_d      = index_q;
        resp_valid_d = 1'b0;
        vmask_d      = vmask_q;
        dmask_d      = dmask_q;
        en_c         = 1'b0;
        we_c         = 1'b0;
        idx_c        = lookup_index;
        way_c        = 2'd0;
        din_c        = '0;
        fill_ready   = 1'b0;
        lookup_ready = 1'b0;
        flush_busy   = 1'b0;
        fill_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                fill_ready   = !flush_req;
                lookup_ready = !flush_req && !fill_valid;
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (fill_valid) begin
                    index_d = fill_index;
                    state_d = S_FILL_RD;
                end else if (lookup_valid) begin
                    en_c         = 1'b1;
                    resp_valid_d = 1'b1;
                    vmask_d      = rd_vmask;
                    dmask_d      = rd_dmask;
                end
            end
            S_FILL_RD: begin
                en_c     = 1'b1;
                idx_c    = index_q;
                victim_d = sel_victim;
                use_rr_d = sel_use_rr;
                state_d  = S_FILL_WR;
            end
            S_FILL_WR: begin
                en_c      = 1'b1;
                we_c      = 1'b1;
                idx_c     = index_q;
                way_c     = victim_q;
                din_c     = dw'(ST_FILL);
                fill_done = 1'b1;
                if (use_rr_q) rr_ptr_d = rr_ptr_q + 2'd1;
                state_d   = S_IDLE;
            end
            S_FLUSH: begin
                flush_busy = 1'b1;
                en_c       = 1'b1;
                we_c       = 1'b1;
                idx_c      = fcnt_q[FW-1:2];
                way_c      = fcnt_q[1:0];
                fcnt_d     = fcnt_q + 1'b1;
                // Last entry: the increment wraps fcnt back to zero for the next sweep.
                if (&fcnt_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            fcnt_q       <= '0;
            rr_ptr_q     <= 2'd0;
            victim_q     <= 2'd0;
            use_rr_q     <= 1'b0;
            index_q      <= '0;
            resp_valid_q <= 1'b0;
            vmask_q      <= 4'd0;
            dmask_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            rr_ptr_q     <= rr_ptr_d;
            victim_q     <= victim_d;
            use_rr_q     <= use_rr_d;
            index_q      <= index_d;
            resp_valid_q <= resp_valid_d;
            vmask_q      <= vmask_d;
            dmask_q      <= dmask_d;
        end
    end

    // Array strobes are blocked while reset is held, whatever state the FSM sits in.
    assign sram_en    = en_c & ~reset;
    assign sram_we    = we_c & ~reset;
    assign sram_index = idx_c;
    assign sram_way   = way_c;
    assign sram_din   = din_c;

    assign resp_valid = resp_valid_q;
    assign resp_vmask = vmask_q;
    assign resp_dmask = dmask_q;
    assign fill_way   = victim_q;

endmodule

// File: tb/tb_isram_ctrl.sv
// Scoreboard bench for isram_ctrl (aw=2) with a behavioural 4x4 status array model.
module tb_isram_ctrl;
    import icache_pkg::*;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup_valid, lookup_ready;
    logic [AW-1:0] lookup_index;
    logic          resp_valid;
    logic [3:0]    resp_vmask, resp_dmask;
    logic          fill_valid, fill_ready;
    logic [AW-1:0] fill_index;
    logic          fill_done;
    logic [1:0]    fill_way;
    logic          flush_req, flush_busy;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_index;
    logic [1:0]    sram_way, sram_din;
    logic [1:0]    sram_dout0, sram_dout1, sram_dout2, sram_dout3;

    isram_ctrl #(.aw(AW), .dw(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_index (lookup_index),
        .resp_valid   (resp_valid),
        .resp_vmask   (resp_vmask),
        .resp_dmask   (resp_dmask),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_index   (fill_index),
        .fill_done    (fill_done),
        .fill_way     (fill_way),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_index   (sram_index),
        .sram_way     (sram_way),
        .sram_din     (sram_din),
        .sram_dout0   (sram_dout0),
        .sram_dout1   (sram_dout1),
        .sram_dout2   (sram_dout2),
        .sram_dout3   (sram_dout3)
    );

    always #5 clk = ~clk;

    // Status array model; tb_init preloads garbage, poke plants a single entry.
    logic [1:0]    mem [4][4];
    logic          tb_init, poke;
    logic [1:0]    poke_set, poke_way, poke_val;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 4; w++)
                    mem[s][w] <= 2'b11;
        end else if (poke) begin
            mem[poke_set][poke_way] <= poke_val;
        end else if (sram_en && sram_we) begin
            mem[sram_index][sram_way] <= sram_din;
        end
    end

    assign sram_dout0 = mem[sram_index][0];
    assign sram_dout1 = mem[sram_index][1];
    assign sram_dout2 = mem[sram_index][2];
    assign sram_dout3 = mem[sram_index][3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] d;
        int         due;
    } resp_t;

    typedef struct {
        logic [1:0] way;
        int         due;
    } fill_t;

    resp_t resp_q[$];
    fill_t fill_q[$];

    // Monitor: pops an expectation whenever the DUT strobes a response or fill completion.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got resp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("resp_cycle", cyc, e.due);
                check("resp_vmask", resp_vmask, e.v);
                check("resp_dmask", resp_dmask, e.d);
            end
        end
        if (fill_done) begin
            if (fill_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fill_unexpected: got fill_done=1 expected none (cycle %0d)", cyc);
            end else begin
                fill_t f;
                f = fill_q.pop_front();
                check("fill_cycle", cyc, f.due);
                check("fill_way", fill_way, f.way);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic lookup(input logic [1:0] idx, input logic [3:0] v, input logic [3:0] d);
        bit ok = 0;
        lookup_valid = 1'b1;
        lookup_index = idx;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (lookup_ready) begin
                resp_q.push_back('{v: v, d: d, due: cyc + 1});
                ok = 1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL lookup_timeout: got no lookup_ready expected acceptance (set %0d)", idx);
        end
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    task automatic fill(input logic [1:0] idx, input logic [1:0] way);
        bit ok = 0;
        fill_valid = 1'b1;
        fill_index = idx;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (fill_ready) begin
                fill_q.push_back('{way: way, due: cyc + 2});
                ok = 1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fill_timeout: got no fill_ready expected acceptance (set %0d)", idx);
        end
        @(posedge clk); #1;
        fill_valid = 1'b0;
        fill_index = ~idx;
        @(negedge clk);
        check("fill_ready_rd", fill_ready, 1'b0);
        @(negedge clk);
        check("fill_ready_wr", fill_ready, 1'b0);
        @(posedge clk); #1;
    endtask

    // Called during the first FLUSH cycle; expects exactly 16 busy cycles with both readies low.
    task automatic sweep_check();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("sweep_busy_rdy", {flush_busy, lookup_ready, fill_ready}, 3'b100);
        end
        @(posedge clk); #1;
        check("sweep_end", flush_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        tb_init      = 1'b1;
        poke         = 1'b0;
        poke_set     = 2'd0;
        poke_way     = 2'd0;
        poke_val     = 2'd0;
        lookup_valid = 1'b0;
        lookup_index = '0;
        fill_valid   = 1'b0;
        fill_index   = '0;
        flush_req    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {resp_valid, fill_done, sram_en, sram_we}, 4'b0000);
        check("rst_masks", {resp_vmask, resp_dmask, fill_way}, 10'd0);
        @(posedge clk); #1;
        tb_init = 1'b0;
        reset   = 1'b0;

`ifdef ISRAM_RESET_FLUSH_EN
        sweep_check();
`else
        check("idle_after_rst", flush_busy, 1'b0);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        sweep_check();
`endif

        // Every set reads invalid after the sweep.
        for (int s = 0; s < 4; s++) lookup(2'(s), 4'b0000, 4'b0000);

        // Plant a dirty+valid entry in set 0 way 2.
        poke = 1'b1; poke_set = 2'd0; poke_way = 2'd2; poke_val = 2'b11;
        @(posedge clk); #1;
        poke = 1'b0;
        lookup(2'd0, 4'b0100, 4'b0100);

        // Flush wins over a simultaneous fill, which then runs on the cleared array.
        flush_req  = 1'b1;
        fill_valid = 1'b1;
        fill_index = 2'd0;
        @(negedge clk);
        check("prio_ready", {fill_ready, lookup_ready}, 2'b00);
        @(posedge clk); #1;
        flush_req = 1'b0;
        sweep_check();
        fill(2'd0, 2'd0);

        // Four fills take the invalid ways in order, then round-robin from 0.
        fill(2'd3, 2'd0);
        fill(2'd3, 2'd1);
        fill(2'd3, 2'd2);
        fill(2'd3, 2'd3);
        fill(2'd3, 2'd0);
        fill(2'd3, 2'd1);
        lookup(2'd3, 4'b1111, 4'b0000);

        fill(2'd2, 2'd0);
        fill(2'd2, 2'd1);

        // Back-to-back lookups; set 1 stays empty despite fill_index toggling after acceptance.
        lookup(2'd0, 4'b0001, 4'b0000);
        lookup(2'd1, 4'b0000, 4'b0000);
        lookup(2'd2, 4'b0011, 4'b0000);

        // Reset during FILL_RD abandons the fill.
        fill_valid = 1'b1;
        fill_index = 2'd1;
        @(negedge clk);
        check("abort_fill_ready", fill_ready, 1'b1);
        @(posedge clk); #1;
        fill_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check("abort_rst_gate", {sram_en, sram_we, fill_done}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef ISRAM_RESET_FLUSH_EN
        sweep_check();
`endif
        lookup(2'd1, 4'b0000, 4'b0000);

        repeat (4) @(posedge clk);
        #1;
        check("resp_q_drained", resp_q.size(), 0);
        check("fill_q_drained", fill_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
